// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS fetch stage.
//   fetch_state_t     - fetch controller states (BOOT, RUN, HALT)
//   WORD_BYTES        - bytes per instruction word (PC step)
//   HALT_WORD_DEFAULT - sentinel instruction word that stops fetching
//   is_word_aligned   - true when a byte address sits on a word boundary
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int          WORD_BYTES        = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC selection for the fetch stage.
// Ports:
//   pc              in  32  current program counter
//   redirect_en     in  1   branch/jump redirect request
//   redirect_target in  32  byte address to redirect to
//   next_pc         out 32  redirect target when redirecting, else pc + 4
//   misalign        out 1   redirect requested to a non-word-aligned target
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  // Sequential fetch wraps modulo 2^32; the range check upstream stops
  // fetching long before a wrap could be observed.
  assign next_pc  = redirect_en ? redirect_target : pc + 32'(WORD_BYTES);
  assign misalign = redirect_en && !is_word_aligned(redirect_target);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the single-cycle MIPS core.
// Owns the PC, drives it onto the combinational instruction memory and
// captures the returned word into an output register with a valid flag.
// Parameters:
//   DEPTH     instruction memory size in bytes (legal PCs 0 .. DEPTH-4)
//   RESET_PC  PC loaded on reset
//   HALT_WORD instruction word that stops fetching (never delivered)
// Ports:
//   CLK             in  1   clock, rising edge
//   RST             in  1   synchronous active-high reset
//   Stall           in  1   hold PC and output register
//   Redirect_en     in  1   load PC from Redirect_target, flush output
//   Redirect_target in  32  byte address of next instruction
//   Read_address    out 32  byte address to instruction memory (= PC)
//   RD              in  32  instruction word from memory, same cycle
//   Instr           out 32  captured instruction
//   Instr_PC        out 32  address Instr was fetched from
//   Instr_valid     out 1   Instr/Instr_PC hold a live instruction
//   Halted          out 1   fetch stopped (sentinel or fault)
//   Fault           out 1   stop caused by misaligned target or bad PC
//   Fetch_count     out 32  instructions delivered, saturating
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall,
  input  logic        Redirect_en,
  input  logic [31:0] Redirect_target,
  output logic [31:0] Read_address,
  input  logic [31:0] RD,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic        Instr_valid,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] Fetch_count
);

  // Highest byte address that still holds a whole instruction word.
  localparam logic [31:0] LAST_PC = 32'(DEPTH - WORD_BYTES);

  fetch_state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        misalign;

  // Control decisions produced by the FSM for the datapath register block.
  logic pc_load;     // PC <= next_pc (redirect or sequential advance)
  logic capture;     // deliver RD as a new instruction
  logic valid_clr;   // drop the currently held instruction
  logic enter_halt;  // stop fetching on this edge
  logic fault_set;   // the stop is a fault rather than the sentinel

  next_pc_sel u_next_pc_sel (
    .pc              (pc),
    .redirect_en     (Redirect_en),
    .redirect_target (Redirect_target),
    .next_pc         (next_pc),
    .misalign        (misalign)
  );

  assign Read_address = pc;

  // NOTE: state-holding registers use non-blocking (<=) assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= BOOT;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    capture    = 1'b0;
    valid_clr  = 1'b0;
    enter_halt = 1'b0;
    fault_set  = 1'b0;

    unique case (state)
      BOOT: state_next = RUN;

      RUN: begin
        if (Redirect_en) begin
          // Redirect outranks stall, range and sentinel checks this cycle.
          valid_clr = 1'b1;
          if (misalign) begin
            state_next = HALT;
            enter_halt = 1'b1;
            fault_set  = 1'b1;
          end else begin
            pc_load = 1'b1;
          end
        end else if (Stall) begin
          // Everything holds, including Instr_valid.
        end else if (pc > LAST_PC) begin
          state_next = HALT;
          enter_halt = 1'b1;
          fault_set  = 1'b1;
          valid_clr  = 1'b1;
        end else if (RD == HALT_WORD) begin
          state_next = HALT;
          enter_halt = 1'b1;
          valid_clr  = 1'b1;
        end else begin
          capture = 1'b1;
          pc_load = 1'b1;
        end
      end

      HALT: state_next = HALT;

      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= RESET_PC;
      Instr       <= '0;
      Instr_PC    <= '0;
      Instr_valid <= 1'b0;
      Halted      <= 1'b0;
      Fault       <= 1'b0;
      Fetch_count <= '0;
    end else begin
      if (pc_load) pc <= next_pc;

      if (capture) begin
        Instr       <= RD;
        Instr_PC    <= pc;
        Instr_valid <= 1'b1;
        if (Fetch_count != 32'hFFFF_FFFF) Fetch_count <= Fetch_count + 32'd1;
      end else if (valid_clr) begin
        Instr_valid <= 1'b0;
      end

      if (enter_halt) begin
        Halted <= 1'b1;
        Fault  <= fault_set;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the single-cycle MIPS core. Owns the program counter, drives the byte address into the combinational instruction memory, captures the returned 32-bit word into an output register with a valid flag, and applies stall, redirect (branch/jump), halt-sentinel and address-range checks. It sits directly upstream of the instruction memory and feeds the decoder.

## Interface
- DEPTH, 1024, instruction memory size in bytes; legal fetch addresses are 0 .. DEPTH-4
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_WORD, 32'hFFFF_FFFF, instruction word that stops fetching
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- Stall  in  1  hold PC and output register this cycle
- Redirect_en  in  1  load PC from Redirect_target; flush output
- Redirect_target  in  32  byte address of next instruction
- Read_address  out  32  byte address to instruction memory; equals PC combinationally
- RD  in  32  instruction word returned by memory, same cycle
- Instr  out  32  captured instruction
- Instr_PC  out  32  address Instr was fetched from
- Instr_valid  out  1  Instr/Instr_PC hold a live instruction
- Halted  out  1  fetch stopped (sentinel or fault)
- Fault  out  1  stop caused by misaligned target or out-of-range PC
- Fetch_count  out  32  instructions delivered since reset, saturating at 32'hFFFF_FFFF

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset; lasts exactly one cycle; no capture; -> RUN.
- RUN, per edge, priority high to low:
  - Redirect_en: if Redirect_target[1:0] != 0 -> HALT, Fault=1; else PC <= Redirect_target; Instr_valid <= 0. Overrides Stall and halt/range checks in the same cycle.
  - Stall: all registers hold, Instr_valid included.
  - PC > DEPTH-4: -> HALT, Fault=1, Instr_valid <= 0; no capture.
  - RD == HALT_WORD: -> HALT, Fault=0, Instr_valid <= 0; sentinel never delivered.
  - otherwise: Instr <= RD, Instr_PC <= PC, Instr_valid <= 1, PC <= PC + 4, Fetch_count += 1 (saturating).
- HALT: PC, Instr, Instr_PC, Fetch_count frozen; Instr_valid = 0; Halted = 1; Stall and Redirect_en ignored; exit only via RST.
- PC + 4 is modulo 2^32; the range check catches overrun before wrap matters.
- Read_address = PC in all states, including HALT.

## Timing
- Reset values (one edge after RST=1): PC = RESET_PC, Instr = 0, Instr_PC = 0, Instr_valid = 0, Halted = 0, Fault = 0, Fetch_count = 0, state BOOT.
- RST held high keeps all of the above; reset mid-run discards the in-flight instruction with no partial update.
- Latency: word at address A appears on Instr with Instr_valid=1 one edge after PC=A in RUN without stall.
- First valid instruction: second rising edge after RST deasserts (BOOT cycle, then capture).
- Redirect: target is on Read_address the cycle after Redirect_en; its instruction is valid one edge later (one bubble).
- Stall and Redirect_en same cycle: redirect wins.
- Redirect_en and RD == HALT_WORD same cycle: redirect wins; no halt.
- Halted/Fault assert on the same edge that enters HALT.

## Structure
- Shared package mips_pkg: fetch state enum (BOOT, RUN, HALT), WORD_BYTES = 4, HALT_WORD default constant.
- One combinational sub-module natural: next_pc_sel (inputs PC, Redirect_en, Redirect_target; outputs next PC and misalign flag). FSM, range check and counters remain in fetch_unit.

## Test plan
- Reset then memory holds 0x20080005, 0x20090003 at 0x0, 0x4 -> edge 2: Instr=0x20080005, Instr_PC=0; edge 3: Instr=0x20090003, Instr_PC=4; Fetch_count=2.
- Stall high 3 cycles at PC=0x8 -> Read_address stays 0x8, Instr/Instr_valid unchanged, Fetch_count unchanged; resumes at 0x8 on release.
- Redirect_en with Stall at PC=0x10, target 0x40 -> next cycle Read_address=0x40, Instr_valid=0; following edge Instr_PC=0x40, Instr_valid=1.
- Redirect target 0x42 -> Halted=1, Fault=1, Instr_valid=0; later Redirect to 0x0 ignored; RST restores PC=0, Halted=0.
- Word 0xFFFFFFFF at 0xC -> after delivering 0x8, Halted=1, Fault=0, Instr_PC=0x8, Fetch_count=3; same sentinel with simultaneous redirect to 0x20 -> no halt, PC=0x20.
- DEPTH=16, straight-line code -> instructions 0x0..0xC delivered, then Halted=1, Fault=1 with PC=0x10.
